// File: rtl/verifier_coeff_rx.sv
// Sum-check round-polynomial receiver: assembles each round's coefficients and kicks one verifier layer per round.
// Optional field-range check of incoming words is built when VERIFIER_COEFF_RX_RANGECHECK_EN is defined.

`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1fffffffffffffff
`endif

module verifier_coeff_rx #(
    parameter int nInputs     = 8,
    parameter int nCopyBits   = 3,
    localparam int nInBits    = $clog2(nInputs),
    localparam int lastCoeff  = (nInBits > 3) ? nInBits : 3,
    localparam int nRounds    = nCopyBits + 2 * nInBits + 1,
    localparam int roundBits  = (nRounds > 1) ? $clog2(nRounds) : 1
) (
    input  logic                                 clk,
    input  logic                                 rstb,
    input  logic                                 start,
    input  logic                                 in_valid,
    input  logic [`F_NBITS-1:0]                  in_data,
    output logic                                 in_ready,
    output logic [lastCoeff:0][`F_NBITS-1:0]     c_out,
    output logic                                 lay_en,
    output logic                                 lay_restart,
    input  logic                                 lay_ready,
    output logic [roundBits-1:0]                 round_idx,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    localparam int wcntBits = $clog2(lastCoeff + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KICK,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [wcntBits-1:0]   wcnt;
    logic [wcntBits-1:0]   last_word;
    logic                  last_round;
    logic                  accept;

    // Copy rounds carry cubics, input rounds quadratics, the final round a degree-nInBits poly.
    always_comb begin
        last_word = wcntBits'(nInBits);
        if (int'(round_idx) < nCopyBits) begin
            last_word = wcntBits'(3);
        end else if (int'(round_idx) < nCopyBits + 2 * nInBits) begin
            last_word = wcntBits'(2);
        end
    end

    assign last_round = (round_idx == roundBits'(nRounds - 1));
    assign in_ready   = (state == ST_LOAD);
    assign accept     = in_valid && in_ready;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept && (wcnt == last_word)) begin
                    state_next = ST_KICK;
                end
            end
            ST_KICK: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (lay_ready) begin
                    state_next = last_round ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Kick and done are registered from the next state so the layer sees clean single-cycle pulses.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            c_out       <= '0;
            wcnt        <= '0;
            round_idx   <= '0;
            lay_en      <= 1'b0;
            lay_restart <= 1'b0;
            done        <= 1'b0;
        end else begin
            lay_en      <= (state_next == ST_KICK);
            lay_restart <= (state_next == ST_KICK) && (round_idx == '0);
            done        <= (state_next == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        round_idx <= '0;
                        wcnt      <= '0;
                        c_out     <= '0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        c_out[wcnt] <= in_data;
                        wcnt        <= wcnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (lay_ready && !last_round) begin
                        round_idx <= round_idx + 1'b1;
                        wcnt      <= '0;
                        c_out     <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef VERIFIER_COEFF_RX_RANGECHECK_EN
    // Out-of-field words are still stored; the flag only reports the protocol violation.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            err <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            err <= 1'b0;
        end else if (accept && (in_data >= `F_Q)) begin
            err <= 1'b1;
        end
    end
`else
    always_comb begin
        err = 1'b0;
    end
`endif

endmodule

// File: doc/verifier_coeff_rx.md
Name: verifier_coeff_rx

Overview:
- Upstream feeder for one verifier layer.
- Accepts the prover's sum-check round polynomials as a stream of field elements and assembles each round's coefficient vector.
- Presents the vector on c_out, which drives the layer's c_in.
- Issues the one-cycle enable/restart kick that the layer's edge-detected en expects, then waits for the layer to return ready before accepting the next round.
- Sequences all nCopyBits + 2*nInBits + 1 rounds of a layer and reports completion.

Parameters:
- nInputs, 8, layer input count; nInBits = $clog2(nInputs) (derived, do not override).
- nCopyBits, 3, copy-variable rounds (cubic).
- lastCoeff, max(3, nInBits) (derived, do not override), top index of c_out.

Ports:
- clk  in  1  clock.
- rstb  in  1  reset; synchronous, active-low.
- start  in  1  begin a new layer; sampled only in ST_IDLE.
- in_valid  in  1  stream word valid.
- in_data  in  `F_NBITS  coefficient word, lowest-degree coefficient first.
- in_ready  out  1  word accepted when in_valid & in_ready.
- c_out  out  `F_NBITS x (lastCoeff+1)  assembled coefficients, to layer c_in.
- lay_en  out  1  one-cycle kick, to layer en.
- lay_restart  out  1  high with lay_en on round 0 only, to layer restart.
- lay_ready  in  1  layer ready.
- round_idx  out  $clog2(nCopyBits+2*nInBits+1)  current round.
- busy  out  1  not in ST_IDLE.
- done  out  1  one-cycle pulse after the last round completes.
- err  out  1  sticky protocol/range error; cleared by start.

Behaviour:
- Reset (rstb low at posedge) forces these values, from any state including mid-round:
  - state ST_IDLE
  - all c_out entries 0, round_idx 0, word counter 0
  - in_ready, lay_en, lay_restart, done, err all 0
- Word count per round r:
  - r < nCopyBits: 4 words.
  - r < nCopyBits + 2*nInBits: 3 words.
  - final round: nInBits + 1 words.
  - Unfilled c_out entries of a round read 0 (cleared on entry to ST_LOAD).
- ST_IDLE:
  - in_ready = 0.
  - On start: round_idx <= 0, err <= 0, clear c_out, go to ST_LOAD.
- ST_LOAD:
  - in_ready = 1.
  - Each handshake writes c_out[wcnt] <= in_data and increments wcnt.
  - On the handshake of the last word of the round: go to ST_KICK.
  - In that transition cycle in_ready stays 1, but the next state has in_ready = 0, so no extra word is accepted.
- ST_KICK (exactly 1 cycle):
  - lay_en = 1; lay_restart = (round_idx == 0); go to ST_WAIT.
  - lay_en is registered and low in every other state, so each round produces exactly one rising edge.
- ST_WAIT:
  - in_ready = 0; c_out held stable.
  - First cycle with lay_ready = 1 (necessarily at least one cycle after the kick):
    - If round_idx == last round: go to ST_DONE.
    - Otherwise: round_idx++, wcnt <= 0, clear c_out, go to ST_LOAD.
- ST_DONE (1 cycle): done = 1, then ST_IDLE; round_idx keeps its last value.
- start outside ST_IDLE is ignored.
- start and in_valid together in ST_IDLE: only start takes effect; no word is consumed.
- in_valid while in_ready = 0: no effect. The source must hold the word.
- c_out changes only in ST_LOAD, on handshakes or on the clear.
- Latency:
  - The last word handshake is at cycle t; lay_en is high at t+1.
  - The next round's first word is accepted at the earliest in the cycle after lay_ready is sampled high.

Optional Feature:
- Macro: VERIFIER_COEFF_RX_RANGECHECK_EN.
- When defined: each accepted word is compared with the field modulus `F_Q.
  - in_data >= `F_Q sets err.
  - The word is still stored, and sequencing continues.
  - err stays set until the next start.
- When undefined: no comparator is built and err is tied 0.

Test Plan:
- nCopyBits=1, nInBits=2 (6 rounds: 4,3,3,3,3,3 words). Start, then stream words 1..19 with lay_ready returning 3 cycles after each kick. Expect:
  - six lay_en pulses, lay_restart only on the first
  - first kick sees c_out={4,3,2,1} (index 3..0); second sees {0,7,6,5}
  - done one cycle after the 6th lay_ready
- Same config with in_valid toggling 1/0 every cycle. Expect identical c_out at each kick, and no word accepted while in ST_WAIT.
- Hold lay_ready=0 for 20 cycles after the first kick. Expect in_ready=0, c_out={4,3,2,1} stable, and no second lay_en.
- Pull rstb low during round 2, then release. Expect ST_IDLE, all c_out=0, round_idx=0. A new start re-runs from round 0 with lay_restart=1.
- Assert start while busy in round 1. Expect no effect on round_idx or c_out.
- With VERIFIER_COEFF_RX_RANGECHECK_EN: send `F_Q as word 2. Expect err=1 from the next cycle, sequencing unaffected, and err cleared by the next start. Without the macro, err stays 0.
